// File: rtl/prog_clock_divider_pkg.sv
// Shared definitions for the programmable clock divider: channel-select width and
// configuration limits.
package prog_clock_divider_pkg;

    localparam int MIN_PERIOD = 2;

    // Width of the channel-select field; at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: free-running phase counter, active/shadow period and high time,
// and registered clkout/tick outputs.
module prog_clock_divider_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int CNT_W          = 27,
    parameter int DEFAULT_PERIOD = 100000000,
    parameter int DEFAULT_HIGH   = 50000000
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clkout,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] high_sh;
    logic             pending;
    logic             wrap;
    logic             apply;

    assign wrap  = (cnt == period_act - CNT_W'(1));
    // A write landing on the same edge wins over the apply; it is picked up at the next wrap.
    assign apply = pending && !wr && (wrap || !en);

    always_ff @(posedge clkin) begin
        if (wr) begin
            period_sh <= cfg_period;
            high_sh   <= cfg_high;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            clkout     <= 1'b0;
            tick       <= 1'b0;
            pending    <= 1'b0;
            period_act <= CNT_W'(DEFAULT_PERIOD);
            high_act   <= CNT_W'(DEFAULT_HIGH);
        end else begin
            if (en) begin
                clkout <= (cnt < high_act);
                tick   <= (cnt == '0);
                cnt    <= wrap ? '0 : cnt + CNT_W'(1);
            end else begin
                clkout <= 1'b0;
                tick   <= 1'b0;
                cnt    <= '0;
            end
            if (apply) begin
                period_act <= period_sh;
                high_act   <= high_sh;
            end
            if (wr) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick generator: configuration decode, write
// acknowledge/reject strobes and one divider channel per output.
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int CNT_W          = 27,
    parameter  int DEFAULT_PERIOD = 100000000,
    parameter  int DEFAULT_HIGH   = 50000000,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] tick
);

    logic cfg_ok;

    // high <= period-1 is written as high < period so a small period cannot underflow.
    function automatic logic cfg_valid(input logic [CH_W-1:0]  ch,
                                       input logic [CNT_W-1:0] period,
                                       input logic [CNT_W-1:0] high);
        return (int'(ch) < NUM_CH) && (period >= CNT_W'(MIN_PERIOD)) &&
               (high != '0) && (high < period);
    endfunction

    assign cfg_ok = cfg_we && cfg_valid(cfg_ch, cfg_period, cfg_high);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        prog_clock_divider_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_HIGH   (DEFAULT_HIGH)
        ) u_ch (
            .clkin      (clkin),
            .reset      (reset),
            .en         (en[i]),
            .wr         (cfg_ok && (int'(cfg_ch) == i)),
            .cfg_period (cfg_period),
            .cfg_high   (cfg_high),
            .clkout     (clkout[i]),
            .tick       (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with a per-cycle scoreboard of expected
// clkout/tick/ack/err, plus a 3-channel instance for the out-of-range channel case.
module tb_prog_clock_divider;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DP  = 10;
    localparam int DH  = 5;

    logic           clkin = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic [CW-1:0]  cfg_high = '0;
    logic           cfg_ack, cfg_err;
    logic [NCH-1:0] clkout, tick;

    logic           cfg_we3 = 1'b0;
    logic [1:0]     cfg_ch3 = '0;
    logic           cfg_ack3, cfg_err3;
    logic [2:0]     clkout3, tick3;

    prog_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(DP), .DEFAULT_HIGH(DH)) dut (
        .clkin(clkin), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .clkout(clkout), .tick(tick));

    prog_clock_divider #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_PERIOD(DP), .DEFAULT_HIGH(DH)) dut3 (
        .clkin(clkin), .reset(reset), .en(3'b000), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_ack(cfg_ack3), .cfg_err(cfg_err3),
        .clkout(clkout3), .tick(tick3));

    always #5 clkin = ~clkin;

    int        m_cnt[NCH], m_p[NCH], m_h[NCH], m_sp[NCH], m_sh[NCH];
    bit        m_pend[NCH];
    logic [9:0] sb[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    string     tag = "";
    int        hi, tk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_p[i] = DP; m_h[i] = DH; m_pend[i] = 0;
        end
        sb.delete();
    endtask

    // Predict the outputs of the coming edge from the inputs now driven, then compare.
    task automatic step();
        logic [NCH-1:0] ec, et;
        logic [9:0]     e;
        bit             ok, wr, ap;
        ec = '0; et = '0;
        ok = cfg_we && (cfg_period >= 2) && (cfg_high >= 1) && (cfg_high < cfg_period);
        for (int i = 0; i < NCH; i++) begin
            wr = ok && (int'(cfg_ch) == i);
            ap = 0;
            if (en[i]) begin
                ec[i] = (m_cnt[i] < m_h[i]);
                et[i] = (m_cnt[i] == 0);
                if (m_cnt[i] == m_p[i] - 1) begin
                    m_cnt[i] = 0;
                    ap = 1;
                end else begin
                    m_cnt[i]++;
                end
            end else begin
                m_cnt[i] = 0;
                ap = 1;
            end
            if (ap && m_pend[i] && !wr) begin
                m_p[i] = m_sp[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
            end
            if (wr) begin
                m_sp[i] = int'(cfg_period); m_sh[i] = int'(cfg_high); m_pend[i] = 1;
            end
        end
        sb.push_back({ec, et, ok, cfg_we && !ok});
        @(posedge clkin);
        #1;
        e = sb.pop_front();
        check(tag, {22'd0, clkout, tick, cfg_ack, cfg_err}, {22'd0, e});
    endtask

    task automatic write(input logic [1:0] ch, input int p, input int h);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = CW'(p); cfg_high = CW'(h);
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        check("reset_state", {26'd0, clkout, tick, cfg_ack, cfg_err}, 32'd0);
        reset = 1'b0;
        en = 4'hF;

        // 1: defaults, 5 high / 5 low, tick every 10
        tag = "t1_default";
        step();
        check("t1_first_edge", {24'd0, clkout, tick}, 32'hFF);
        hi = int'(clkout[0]);
        for (int k = 0; k < 9; k++) begin step(); hi += int'(clkout[0]); end
        check("t1_high_count", hi, 5);
        repeat (15) step();

        // 2: mid-period write to ch1, applied at the next wrap
        tag = "t2_write";
        for (int k = 0; k < 20 && m_cnt[1] != 4; k++) step();
        write(2'd1, 4, 1);
        for (int k = 0; k < 20 && m_p[1] != 4; k++) step();
        hi = 0; tk = 0;
        for (int k = 0; k < 8; k++) begin
            step(); hi += int'(clkout[1]); tk += int'(tick[1]);
        end
        check("t2_ch1_high", hi, 2);
        check("t2_ch1_tick", tk, 2);

        // 3: rejected writes
        tag = "t3_invalid";
        write(2'd2, 1, 1);
        write(2'd2, 5, 0);
        write(2'd2, 6, 6);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_period = CW'(10); cfg_high = CW'(5);
        step();
        check("t3_ch_range", {30'd0, cfg_ack3, cfg_err3}, 32'd1);
        cfg_we3 = 1'b0;
        repeat (12) step();

        // 4: disable and re-enable ch2
        tag = "t4_enable";
        for (int k = 0; k < 20 && m_cnt[2] != 3; k++) step();
        en[2] = 1'b0;
        step();
        check("t4_off", {31'd0, clkout[2]}, 32'd0);
        repeat (3) step();
        en[2] = 1'b1;
        step();
        check("t4_restart", {30'd0, clkout[2], tick[2]}, 32'd3);
        repeat (5) step();

        // 5: write on a wrap edge, overwritten before the next wrap
        tag = "t5_lastwins";
        for (int k = 0; k < 20 && m_cnt[0] != DP - 1; k++) step();
        write(2'd0, 8, 2);
        repeat (3) step();
        write(2'd0, 6, 3);
        for (int k = 0; k < 20 && m_p[0] != 6; k++) step();
        hi = 0; tk = 0;
        for (int k = 0; k < 12; k++) begin
            step(); hi += int'(clkout[0]); tk += int'(tick[0]);
        end
        check("t5_ch0_high", hi, 6);
        check("t5_ch0_tick", tk, 2);

        // 6: async reset mid-high with a pending write on ch3
        tag = "t6_reset";
        for (int k = 0; k < 20 && !(m_cnt[3] >= 1 && m_cnt[3] <= 3); k++) step();
        write(2'd3, 4, 1);
        #3 reset = 1'b1;
        #1;
        check("t6_async_clear", {26'd0, clkout, tick, cfg_ack, cfg_err}, 32'd0);
        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        check("t6_held", {26'd0, clkout, tick, cfg_ack, cfg_err}, 32'd0);
        reset = 1'b0;
        tag = "t6_after";
        hi = 0;
        for (int k = 0; k < 20; k++) begin step(); hi += int'(clkout[3]); end
        check("t6_ch3_default", hi, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
